fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 28 ++
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcode values,
// instruction field positions and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam logic [1:0] OP_R    = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_LW   = 2'b10;
  localparam logic [1:0] OP_SW   = 2'b11;

  // Field positions within a 16-bit instruction word
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 14;
  localparam int RS_HI  = 13;
  localparam int RS_LO  = 11;
  localparam int RT_HI  = 10;
  localparam int RT_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 5;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_HOLD = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at a time from instruction memory,
// holds it for the decode stage and advances the PC on acceptance.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   redirect_en,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [1:0]             opcode,
  output logic [2:0]             rs,
  output logic [2:0]             rt,
  output logic [2:0]             rd,
  output logic [7:0]             imm,
  output logic [PC_WIDTH-1:0]    instr_pc
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  fetch_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    hold_pc_q, hold_pc_d;
  logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    if (redirect_en) begin
      // Redirect wins over every handshake; an in-flight read keeps going at the new address
      pc_d = redirect_pc;
      if (state_q == ST_REQ) state_d = ST_REQ;
      else                   state_d = run ? ST_REQ : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (run) state_d = ST_REQ;
        ST_REQ: begin
          if (imem_ack) begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_q;
            state_d      = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            pc_d    = pc_q + PC_ONE;
            state_d = run ? ST_REQ : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign opcode      = hold_instr_q[OPC_HI:OPC_LO];
  assign rs          = hold_instr_q[RS_HI:RS_LO];
  assign rt          = hold_instr_q[RT_HI:RT_LO];
  assign rd          = hold_instr_q[RD_HI:RD_LO];
  assign imm         = hold_instr_q[IMM_HI:IMM_LO];
  assign instr_pc    = hold_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: transaction-level reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, run, redirect_en, imem_ack, instr_ready;
  logic [7:0]  redirect_pc;
  logic [15:0] imem_rdata;
  logic        imem_req, instr_valid;
  logic [7:0]  imem_addr, imm, instr_pc;
  logic [1:0]  opcode;
  logic [2:0]  rs, rt, rd;

  int checks = 0;
  int failures = 0;

  // memory model controls
  int          mem_delay = 0;
  int          wcnt = 0;
  bit          ack_force = 0;
  bit          fixed_en = 0;
  logic [15:0] fixed_word = 16'h0000;

  // reference model: is a fetch outstanding, is a word held, and what
  int m_pc = 0, m_instr = 0, m_ipc = 0;
  bit m_fetching = 0, m_have = 0;

  fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .run(run), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_pc = 0; m_instr = 0; m_ipc = 0; m_fetching = 0; m_have = 0;
    end else if (redirect_en) begin
      m_pc = redirect_pc;
      m_have = 0;
      m_fetching = m_fetching || run;
    end else if (m_have) begin
      if (instr_ready) begin
        m_have = 0;
        m_pc = (m_pc + 1) % 256;
        m_fetching = run;
      end
    end else if (m_fetching) begin
      if (imem_ack) begin
        m_have = 1; m_fetching = 0;
        m_instr = imem_rdata; m_ipc = m_pc;
      end
    end else begin
      m_fetching = run;
    end
  endtask

  task automatic compare();
    chk("imem_req", imem_req, m_fetching);
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, m_have);
    chk("opcode", opcode, (m_instr >> 14) & 3);
    chk("rs", rs, (m_instr >> 11) & 7);
    chk("rt", rt, (m_instr >> 8) & 7);
    chk("rd", rd, (m_instr >> 5) & 7);
    chk("imm", imm, m_instr & 255);
    chk("instr_pc", instr_pc, m_ipc);
  endtask

  // One clock: memory answers the current request, model advances, outputs checked.
  task automatic cyc();
    bit req_s;
    req_s = (imem_req === 1'b1);
    imem_ack = ack_force || (req_s && wcnt >= mem_delay);
    imem_rdata = fixed_en ? fixed_word : {8'h00, imem_addr};
    @(posedge clk);
    model_step();
    if (req_s && !imem_ack) wcnt++; else wcnt = 0;
    @(negedge clk);
    compare();
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int n = 0;
    while (instr_valid !== 1'b1 && n < budget) begin cyc(); n++; end
    chk({nm, "_timeout"}, instr_valid, 1'b1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while ((imem_req !== 1'b0 || instr_valid !== 1'b0) && n < budget) begin cyc(); n++; end
    chk({nm, "_timeout"}, {imem_req, instr_valid}, 2'b00);
  endtask

  initial begin
    int ipcs[$];
    int cycs[$];
    logic [7:0] saved;
    reset = 1; run = 0; redirect_en = 0; redirect_pc = 0;
    instr_ready = 0; imem_ack = 0; imem_rdata = 0;
    @(negedge clk);

    // reset state
    cyc(); cyc();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", instr_valid, 0);

    // streaming with zero-wait memory returning word = address
    reset = 0; run = 1; instr_ready = 1;
    cyc();
    chk("first_req", {imem_req, instr_valid, imem_addr}, {2'b10, 8'h00});
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (instr_valid === 1'b1) begin ipcs.push_back(instr_pc); cycs.push_back(c); end
    end
    chk("stream_count", ipcs.size(), 4);
    if (ipcs.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("stream_pc", ipcs[k], k);
        chk("stream_cycle", cycs[k], 2 * k + 1);
      end
    end

    // decode stall with a fixed LW word
    instr_ready = 0; fixed_en = 1; fixed_word = 16'h8A45;
    wait_valid("stall_valid", 10);
    saved = imem_addr;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("stall_valid", instr_valid, 1);
      chk("stall_fields", {opcode, rs, rt, rd, imm}, {2'b10, 3'd1, 3'd2, 3'd2, 8'h45});
      chk("stall_pc", imem_addr, saved);
    end

    // redirect in HOLD coincident with acceptance
    saved = instr_pc + 8'd1;
    fixed_en = 0; instr_ready = 1; redirect_en = 1; redirect_pc = 8'h40;
    cyc();
    redirect_en = 0;
    chk("redir_hold", {imem_req, instr_valid, imem_addr}, {2'b10, 8'h40});
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (imem_req === 1'b1) chk("redir_no_old", imem_addr == saved, 0);
    end

    // PC wrap at 8'hFF
    redirect_en = 1; redirect_pc = 8'hFF;
    cyc();
    redirect_en = 0;
    wait_valid("wrap_valid", 10);
    chk("wrap_ipc", instr_pc, 8'hFF);
    cyc();
    chk("wrap_addr", {imem_req, imem_addr}, {1'b1, 8'h00});

    // delayed ack, run dropped while waiting
    run = 0;
    wait_idle("drain", 10);
    mem_delay = 3; run = 1;
    cyc();
    chk("dly_req", imem_req, 1);
    run = 0;
    wait_valid("dly_valid", 10);
    chk("dly_ipc", instr_pc, 8'h01);
    cyc();
    chk("dly_idle", {imem_req, instr_valid}, 2'b00);
    for (int k = 0; k < 3; k++) cyc();
    chk("dly_stay_idle", imem_req, 0);

    // redirect while idle with run low
    mem_delay = 0; redirect_en = 1; redirect_pc = 8'h20;
    cyc();
    redirect_en = 0;
    chk("idle_redir", {imem_req, imem_addr}, {1'b0, 8'h20});

    // redirect in REQ with coincident zero-wait ack
    run = 1;
    cyc();
    redirect_en = 1; redirect_pc = 8'h30;
    cyc();
    redirect_en = 0;
    chk("req_redir", {imem_req, instr_valid, imem_addr}, {2'b10, 8'h30});
    cyc();
    chk("req_redir_word", {instr_valid, instr_pc, imm}, {1'b1, 8'h30, 8'h30});

    // reset during REQ, then a stray ack; reset beats redirect
    mem_delay = 5;
    cyc();
    chk("pre_rst_req", imem_req, 1);
    reset = 1; ack_force = 1; redirect_en = 1; redirect_pc = 8'h77;
    cyc();
    reset = 0; redirect_en = 0; run = 0;
    chk("rst_mid", {imem_req, instr_valid, imem_addr, instr_pc, opcode, rs, rt, rd, imm}, 37'h0);
    cyc(); cyc();
    chk("rst_late_ack", {imem_req, instr_valid, imem_addr, instr_pc, opcode, rs, rt, rd, imm}, 37'h0);
    ack_force = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
